peak_hold_cmp: RTL and testbench

Windowed peak tracker and threshold comparator with hysteresis alarm for the ANC datapath. It is the parametrised successor of the single-cycle `x > y` comparator. It compares a stream of samples in signed or unsigned mode, reports the maximum of each fixed-length window, and raises a persistent alarm when window peaks stay above a high threshold for a set number of consecutive windows. It sits on the error-microphone / residual path and flags loss of cancellation to the adaptation controller.

---
 rtl/peak_hold_cmp.sv | 147 ++++++++++++++
 tb/tb_peak_hold_cmp.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_hold_cmp.sv
// peak_hold_cmp: windowed peak tracker with a registered sample-vs-threshold
// compare and a hysteresis alarm driven by consecutive over-threshold window
// peaks. SIGNED selects two's-complement or unsigned ordering for every compare.
module peak_hold_cmp #(
    parameter int SIG_WIDTH = 7,
    parameter int WIN_LEN   = 16,
    parameter int SIGNED    = 0,
    parameter int HOLD_CNT  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_valid,
    input  logic [SIG_WIDTH-1:0] x,
    input  logic [SIG_WIDTH-1:0] thr_hi,
    input  logic [SIG_WIDTH-1:0] thr_lo,
    output logic                 x_grtr_thr,
    output logic                 peak_valid,
    output logic [SIG_WIDTH-1:0] peak,
    output logic                 alarm
);

    localparam int CNT_W = $clog2(WIN_LEN);
    localparam int HIT_W = $clog2(HOLD_CNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);
    localparam logic [HIT_W-1:0] HOLD_MAX = HIT_W'(HOLD_CNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        ALARM  = 2'd2
    } state_t;

    // Strict greater-than in the configured number format; one extra bit
    // lets both modes share a single signed compare.
    function automatic logic gt(input logic [SIG_WIDTH-1:0] a,
                                input logic [SIG_WIDTH-1:0] b);
        logic signed [SIG_WIDTH:0] sa;
        logic signed [SIG_WIDTH:0] sb;
        if (SIGNED != 0) begin
            sa = {a[SIG_WIDTH-1], a};
            sb = {b[SIG_WIDTH-1], b};
        end else begin
            sa = {1'b0, a};
            sb = {1'b0, b};
        end
        return sa > sb;
    endfunction

    logic [CNT_W-1:0]     cnt;
    logic [SIG_WIDTH-1:0] run_max;
    logic [HIT_W-1:0]     hits;
    logic [HIT_W-1:0]     hits_nxt;
    state_t               state;
    state_t               state_nxt;

    logic                 close_p0;
    logic                 first_p0;
    logic [SIG_WIDTH-1:0] win_max_p0;
    logic                 peak_hi_p0;
    logic                 peak_lo_p0;

    // Stage 0: window position and the maximum including the current sample
    always_comb begin
        close_p0   = x_valid && (cnt == LAST_CNT);
        first_p0   = (cnt == '0);
        win_max_p0 = gt(x, run_max) ? x : run_max;
        peak_hi_p0 = gt(win_max_p0, thr_hi);
        peak_lo_p0 = gt(thr_lo, win_max_p0);
    end

    // Window counter, running maximum, peak capture and sample compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            run_max    <= '0;
            peak       <= '0;
            peak_valid <= 1'b0;
            x_grtr_thr <= 1'b0;
        end else begin
            peak_valid <= close_p0;
            if (x_valid) begin
                cnt        <= close_p0 ? '0 : cnt + CNT_W'(1);
                run_max    <= first_p0 ? x : win_max_p0;
                x_grtr_thr <= gt(x, thr_hi);
            end
            if (close_p0) begin
                peak <= win_max_p0;
            end
        end
    end

    // Alarm state and hit counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hits  <= '0;
        end else begin
            state <= state_nxt;
            hits  <= hits_nxt;
        end
    end

    // Alarm next-state: only a closing window can move the FSM
    always_comb begin
        state_nxt = state;
        hits_nxt  = hits;
        if (close_p0) begin
            case (state)
                IDLE: begin
                    if (peak_hi_p0) begin
                        if (HOLD_CNT == 1) begin
                            hits_nxt  = HOLD_MAX;
                            state_nxt = ALARM;
                        end else begin
                            hits_nxt  = HIT_W'(1);
                            state_nxt = ARMING;
                        end
                    end
                end
                ARMING: begin
                    if (peak_hi_p0) begin
                        hits_nxt = (hits >= HOLD_MAX) ? HOLD_MAX : hits + HIT_W'(1);
                        if (hits_nxt == HOLD_MAX) begin
                            state_nxt = ALARM;
                        end
                    end else begin
                        hits_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end
                ALARM: begin
                    if (peak_lo_p0) begin
                        hits_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    hits_nxt  = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign alarm = (state == ALARM);

endmodule

// File: tb/tb_peak_hold_cmp.sv
// Bench for peak_hold_cmp: an unsigned and a signed instance share one
// stimulus stream; expected responses are queued by the stimulus and
// consumed by an independent monitor on the falling edge.
module tb_peak_hold_cmp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x_valid = 1'b0;
    logic [6:0] x = '0;
    logic [6:0] thr_hi = 7'h20;
    logic [6:0] thr_lo = 7'd10;

    logic       u_gtr, u_pv, u_alarm;
    logic [6:0] u_peak;
    logic       s_gtr, s_pv, s_alarm;
    logic [6:0] s_peak;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [6:0] pu;
        logic [6:0] ps;
        logic       al_u;
        logic       al_s;
    } pk_t;

    logic gq_u[$];
    logic gq_s[$];
    pk_t  pq[$];

    logic       vld_d = 1'b0;
    logic       last_gu = 1'b0;
    logic       last_gs = 1'b0;
    logic [6:0] last_pu = '0;
    logic [6:0] last_ps = '0;

    peak_hold_cmp #(.SIG_WIDTH(7), .WIN_LEN(4), .SIGNED(0), .HOLD_CNT(2)) u_uns (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .x_grtr_thr(u_gtr), .peak_valid(u_pv), .peak(u_peak), .alarm(u_alarm)
    );

    peak_hold_cmp #(.SIG_WIDTH(7), .WIN_LEN(4), .SIGNED(1), .HOLD_CNT(2)) u_sgn (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .x_grtr_thr(s_gtr), .peak_valid(s_pv), .peak(s_peak), .alarm(s_alarm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) vld_d <= x_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [6:0] v, input logic gu, input logic gs);
        x       = v;
        x_valid = 1'b1;
        gq_u.push_back(gu);
        gq_s.push_back(gs);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_peak(input logic [6:0] pu, input logic [6:0] ps,
                            input logic au, input logic as_v);
        pk_t e;
        e.pu   = pu;
        e.ps   = ps;
        e.al_u = au;
        e.al_s = as_v;
        pq.push_back(e);
    endtask

    // One window with peak p: samples 2, p, 1, 0; g is p's compare vs thr_hi
    task automatic win(input logic [6:0] p, input logic g, input logic al);
        send(7'd2, 1'b0, 1'b0);
        send(p, g, g);
        send(7'd1, 1'b0, 1'b0);
        exp_peak(p, p, al, al);
        send(7'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        check({tag, "_gtr_u"},   32'(u_gtr),   32'd0);
        check({tag, "_gtr_s"},   32'(s_gtr),   32'd0);
        check({tag, "_pv_u"},    32'(u_pv),    32'd0);
        check({tag, "_pv_s"},    32'(s_pv),    32'd0);
        check({tag, "_peak_u"},  32'(u_peak),  32'd0);
        check({tag, "_peak_s"},  32'(s_peak),  32'd0);
        check({tag, "_alarm_u"}, 32'(u_alarm), 32'd0);
        check({tag, "_alarm_s"}, 32'(s_alarm), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        x_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare DUT outputs against queued expectations
    initial begin
        pk_t e;
        logic gu, gs;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_gu = 1'b0;
                last_gs = 1'b0;
                last_pu = '0;
                last_ps = '0;
            end else begin
                if (vld_d) begin
                    if (gq_u.size() == 0 || gq_s.size() == 0) begin
                        check("gtr_queue_empty", 32'd1, 32'd0);
                    end else begin
                        gu = gq_u.pop_front();
                        gs = gq_s.pop_front();
                        check("gtr_u", 32'(u_gtr), 32'(gu));
                        check("gtr_s", 32'(s_gtr), 32'(gs));
                        last_gu = gu;
                        last_gs = gs;
                    end
                end else begin
                    check("gtr_hold_u", 32'(u_gtr), 32'(last_gu));
                    check("gtr_hold_s", 32'(s_gtr), 32'(last_gs));
                end
                if (u_pv || s_pv) begin
                    check("pv_u", 32'(u_pv), 32'd1);
                    check("pv_s", 32'(s_pv), 32'd1);
                    if (pq.size() == 0) begin
                        check("unexpected_peak_valid", 32'd1, 32'd0);
                    end else begin
                        e = pq.pop_front();
                        check("peak_u",  32'(u_peak),  32'(e.pu));
                        check("peak_s",  32'(s_peak),  32'(e.ps));
                        check("alarm_u", 32'(u_alarm), 32'(e.al_u));
                        check("alarm_s", 32'(s_alarm), 32'(e.al_s));
                        last_pu = e.pu;
                        last_ps = e.ps;
                    end
                end else begin
                    check("peak_hold_u", 32'(u_peak), 32'(last_pu));
                    check("peak_hold_s", 32'(s_peak), 32'(last_ps));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        #1;
        chk_reset_state("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Unsigned peak and latency (signed instance agrees on small values)
        thr_hi = 7'h20;
        thr_lo = 7'd10;
        send(7'd3, 1'b0, 1'b0);
        send(7'd9, 1'b0, 1'b0);
        send(7'd5, 1'b0, 1'b0);
        exp_peak(7'd9, 7'd9, 1'b0, 1'b0);
        send(7'd2, 1'b0, 1'b0);
        idle(3);
        do_reset("rst1");

        // Signed vs unsigned ordering, back-to-back
        send(7'h40, 1'b1, 1'b0);
        send(7'h05, 1'b0, 1'b0);
        send(7'h3F, 1'b1, 1'b1);
        exp_peak(7'h40, 7'h3F, 1'b0, 1'b0);
        send(7'h10, 1'b0, 1'b0);
        idle(2);
        do_reset("rst2");

        // Same samples with idle gaps of 1, 0 and 3 cycles
        send(7'h40, 1'b1, 1'b0);
        idle(1);
        send(7'h05, 1'b0, 1'b0);
        send(7'h3F, 1'b1, 1'b1);
        idle(3);
        exp_peak(7'h40, 7'h3F, 1'b0, 1'b0);
        send(7'h10, 1'b0, 1'b0);
        idle(3);
        do_reset("rst3");

        // Alarm hysteresis: thr_hi 20, thr_lo 10
        thr_hi = 7'd20;
        thr_lo = 7'd10;
        win(7'd25, 1'b1, 1'b0);
        win(7'd30, 1'b1, 1'b1);
        win(7'd15, 1'b0, 1'b1);
        win(7'd10, 1'b0, 1'b1);
        win(7'd9,  1'b0, 1'b0);

        // Arming abort on equality, then a clean double hit
        win(7'd25, 1'b1, 1'b0);
        win(7'd20, 1'b0, 1'b0);
        win(7'd25, 1'b1, 1'b0);
        win(7'd5,  1'b0, 1'b0);
        win(7'd25, 1'b1, 1'b0);
        win(7'd25, 1'b1, 1'b1);

        // Reset mid-window with alarm high; 100 is negative in signed mode
        send(7'd100, 1'b1, 1'b0);
        send(7'd100, 1'b1, 1'b0);
        do_reset("rst_mid");
        send(7'd1, 1'b0, 1'b0);
        send(7'd2, 1'b0, 1'b0);
        send(7'd3, 1'b0, 1'b0);
        exp_peak(7'd4, 7'd4, 1'b0, 1'b0);
        send(7'd4, 1'b0, 1'b0);
        idle(4);

        check("gtr_queue_drained",  32'(gq_u.size() + gq_s.size()), 32'd0);
        check("peak_queue_drained", 32'(pq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
